// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM-to-WB instruction bus feeding writeback_stage
interface writeback_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic        in_mem_to_reg;
   logic        in_link;
   logic [1:0]  in_load_size;
   logic        in_load_unsigned;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_rdata;
   logic [31:0] in_pc_plus4;
   logic [4:0]  in_write_reg;

   modport master (
      output in_valid, in_reg_write, in_mem_to_reg, in_link, in_load_size,
             in_load_unsigned, in_addr_lo, in_alu_result, in_mem_rdata,
             in_pc_plus4, in_write_reg,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_reg_write, in_mem_to_reg, in_link, in_load_size,
             in_load_unsigned, in_addr_lo, in_alu_result, in_mem_rdata,
             in_pc_plus4, in_write_reg,
      output in_ready
   );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register and write-back formatter; WB_FWD_EN adds EX bypass outputs
module writeback_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic             flush,
   writeback_stage_if.slave mem,
   output logic             RegWrite,
   output logic [4:0]       write_reg,
   output logic [31:0]      write_data,
   output logic [CNT_W-1:0] retire_count,
   output logic             misalign_err
`ifdef WB_FWD_EN
   ,
   output logic             fwd_valid,
   output logic [4:0]       fwd_reg,
   output logic [31:0]      fwd_data
`endif
);

   logic        s_valid;
   logic        s_reg_write;
   logic        s_mem_to_reg;
   logic        s_link;
   logic [1:0]  s_load_size;
   logic        s_load_unsigned;
   logic [1:0]  s_addr_lo;
   logic [31:0] s_alu_result;
   logic [31:0] s_mem_rdata;
   logic [31:0] s_pc_plus4;
   logic [4:0]  s_write_reg;

   logic        capture;
   logic        s_misaligned;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_fmt;

   // Both flush and hold turn the incoming slot into a bubble.
   assign capture      = ~flush & ~hold;
   assign mem.in_ready = ~hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid         <= 1'b0;
         s_reg_write     <= 1'b0;
         s_mem_to_reg    <= 1'b0;
         s_link          <= 1'b0;
         s_load_size     <= 2'd0;
         s_load_unsigned <= 1'b0;
         s_addr_lo       <= 2'd0;
         s_alu_result    <= 32'd0;
         s_mem_rdata     <= 32'd0;
         s_pc_plus4      <= 32'd0;
         s_write_reg     <= 5'd0;
      end else if (capture) begin
         s_valid         <= mem.in_valid;
         s_reg_write     <= mem.in_reg_write;
         s_mem_to_reg    <= mem.in_mem_to_reg;
         s_link          <= mem.in_link;
         s_load_size     <= mem.in_load_size;
         s_load_unsigned <= mem.in_load_unsigned;
         s_addr_lo       <= mem.in_addr_lo;
         s_alu_result    <= mem.in_alu_result;
         s_mem_rdata     <= mem.in_mem_rdata;
         s_pc_plus4      <= mem.in_pc_plus4;
         s_write_reg     <= mem.in_write_reg;
      end else begin
         s_valid         <= 1'b0;
      end
   end

   // Reserved size 3 behaves as a word access for alignment and formatting.
   assign s_misaligned = s_mem_to_reg &
                         (((s_load_size == 2'd1) & s_addr_lo[0]) |
                          (s_load_size[1] & (s_addr_lo != 2'd0)));

   always_comb begin
      ld_byte = 8'd0;
      case (s_addr_lo)
         2'd0:    ld_byte = s_mem_rdata[7:0];
         2'd1:    ld_byte = s_mem_rdata[15:8];
         2'd2:    ld_byte = s_mem_rdata[23:16];
         default: ld_byte = s_mem_rdata[31:24];
      endcase
      ld_half = s_addr_lo[1] ? s_mem_rdata[31:16] : s_mem_rdata[15:0];
      case (s_load_size)
         2'd0:    load_fmt = {{24{~s_load_unsigned & ld_byte[7]}}, ld_byte};
         2'd1:    load_fmt = {{16{~s_load_unsigned & ld_half[15]}}, ld_half};
         default: load_fmt = s_mem_rdata;
      endcase
   end

   assign write_reg  = s_write_reg;
   assign write_data = s_link       ? s_pc_plus4 + 32'd4 :
                       s_mem_to_reg ? load_fmt : s_alu_result;
   assign RegWrite   = s_valid & s_reg_write & (s_write_reg != 5'd0) & ~s_misaligned;

   // Misaligned loads still retire; only their register write is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count <= '0;
         misalign_err <= 1'b0;
      end else begin
         if (s_valid && (retire_count != '1))
            retire_count <= retire_count + CNT_W'(1);
         if (s_valid && s_misaligned)
            misalign_err <= 1'b1;
      end
   end

`ifdef WB_FWD_EN
   assign fwd_valid = RegWrite;
   assign fwd_reg   = write_reg;
   assign fwd_data  = write_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage against a behavioural model
module tb_writeback_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hold = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   writeback_stage_if bus ();
   writeback_stage_if bus4 ();

   logic        rw, rw4, err, err4;
   logic [4:0]  wr, wr4;
   logic [31:0] wd, wd4, cnt;
   logic [3:0]  cnt4;
`ifdef WB_FWD_EN
   logic        fv, fv4;
   logic [4:0]  fr, fr4;
   logic [31:0] fd, fd4;
`endif

   writeback_stage #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .mem(bus),
      .RegWrite(rw), .write_reg(wr), .write_data(wd),
      .retire_count(cnt), .misalign_err(err)
`ifdef WB_FWD_EN
      , .fwd_valid(fv), .fwd_reg(fr), .fwd_data(fd)
`endif
   );

   writeback_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .mem(bus4),
      .RegWrite(rw4), .write_reg(wr4), .write_data(wd4),
      .retire_count(cnt4), .misalign_err(err4)
`ifdef WB_FWD_EN
      , .fwd_valid(fv4), .fwd_reg(fr4), .fwd_data(fd4)
`endif
   );

   int n_cmp = 0;
   int n_fail = 0;

   // Model state: what the WB slot holds and the architectural counters.
   logic        m_valid = 1'b0, m_mis = 1'b0;
   logic        exp_rw = 1'b0, exp_err = 1'b0;
   logic [4:0]  exp_wr = 5'd0;
   logic [31:0] exp_wd = 32'd0, exp_count = 32'd0;

   function automatic logic [31:0] ref_data(logic link, logic m2r, logic [1:0] size, logic uns,
                                            logic [1:0] lo, logic [31:0] alu, logic [31:0] rdata,
                                            logic [31:0] pc4);
      logic [31:0] v;
      if (link) return pc4 + 32'd4;
      if (!m2r) return alu;
      if (size == 2'd0) begin
         v = (rdata >> (8 * int'(lo))) & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         v = (rdata >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic ref_mis(logic m2r, logic [1:0] size, logic [1:0] lo);
      if (!m2r) return 1'b0;
      if (size == 2'd0) return 1'b0;
      if (size == 2'd1) return (int'(lo) % 2) != 0;
      return lo != 2'd0;
   endfunction

   task automatic drive(logic v, logic rwr, logic m2r, logic link, logic [1:0] size, logic uns,
                        logic [1:0] lo, logic [31:0] alu, logic [31:0] rdata, logic [31:0] pc4,
                        logic [4:0] wreg);
      bus.in_valid = v;       bus.in_reg_write = rwr;   bus.in_mem_to_reg = m2r;
      bus.in_link = link;     bus.in_load_size = size;  bus.in_load_unsigned = uns;
      bus.in_addr_lo = lo;    bus.in_alu_result = alu;  bus.in_mem_rdata = rdata;
      bus.in_pc_plus4 = pc4;  bus.in_write_reg = wreg;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
   endtask

   // Advance one clock, updating the model from the inputs presented before the edge.
   task automatic step();
      logic acc, mis;
      acc = bus.in_valid && !hold && !flush;
      mis = ref_mis(bus.in_mem_to_reg, bus.in_load_size, bus.in_addr_lo);
      if (m_valid && exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 32'd1;
      if (m_valid && m_mis) exp_err = 1'b1;
      m_valid = acc;
      m_mis = mis;
      if (acc) begin
         exp_rw = bus.in_reg_write && (bus.in_write_reg != 5'd0) && !mis;
         exp_wr = bus.in_write_reg;
         exp_wd = ref_data(bus.in_link, bus.in_mem_to_reg, bus.in_load_size, bus.in_load_unsigned,
                           bus.in_addr_lo, bus.in_alu_result, bus.in_mem_rdata, bus.in_pc_plus4);
      end else begin
         exp_rw = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      bus4.in_valid = 0; bus4.in_reg_write = 1; bus4.in_mem_to_reg = 0; bus4.in_link = 0;
      bus4.in_load_size = 0; bus4.in_load_unsigned = 0; bus4.in_addr_lo = 0;
      bus4.in_alu_result = 32'h5; bus4.in_mem_rdata = 0; bus4.in_pc_plus4 = 0; bus4.in_write_reg = 5'd3;
      rst_n = 1'b0;
      #12;
      n_cmp++; if ({rw, wr, wd} !== 38'd0) begin n_fail++; $display("FAIL reset_write_port: got %0b/%0d/%h want 0/0/0", rw, wr, wd); end
      n_cmp++; if (cnt !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_counters: got cnt=%0d err=%0b want 0/0", cnt, err); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_alu();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0000_1234, 32'hFFFF_FFFF, 32'd0, 5'd5);
      step();
      n_cmp++; if (rw !== 1'b1 || wr !== 5'd5 || wd !== 32'h1234) begin n_fail++; $display("FAIL alu_write: got %0b/%0d/%h want 1/5/00001234", rw, wr, wd); end
      idle();
      step();
      n_cmp++; if (rw !== 1'b0) begin n_fail++; $display("FAIL alu_single_write: got %0b want 0", rw); end
      n_cmp++; if (cnt !== 32'd1) begin n_fail++; $display("FAIL alu_retire: got %0d want 1", cnt); end
   endtask

   task automatic test_loads();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 32'd0, 32'h80FF_7F01, 32'd0, 5'd8);
      step();
      n_cmp++; if (rw !== 1'b1 || wd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_signed: got %0b/%h want 1/ffffff80", rw, wd); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 32'd0, 32'h80FF_7F01, 32'd0, 5'd9);
      step();
      n_cmp++; if (rw !== 1'b1 || wd !== 32'h0000_00FF) begin n_fail++; $display("FAIL lbu: got %0b/%h want 1/000000ff", rw, wd); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 2'd2, 32'd0, 32'h80FF_7F01, 32'd0, 5'd10);
      step();
      n_cmp++; if (rw !== 1'b1 || wd !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_signed: got %0b/%h want 1/ffff80ff", rw, wd); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 2'd0, 32'd0, 32'h80FF_7F01, 32'd0, 5'd11);
      step();
      n_cmp++; if (wd !== 32'h0000_7F01) begin n_fail++; $display("FAIL lhu: got %h want 00007f01", wd); end
   endtask

   task automatic test_link_and_zero();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h1111_1111, 32'd0, 32'h0040_0010, 5'd31);
      step();
      n_cmp++; if (rw !== 1'b1 || wr !== 5'd31 || wd !== 32'h0040_0014) begin n_fail++; $display("FAIL link: got %0b/%0d/%h want 1/31/00400014", rw, wr, wd); end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0000_DEAD, 32'd0, 32'd0, 5'd0);
      step();
      n_cmp++; if (rw !== 1'b0 || wd !== 32'h0000_DEAD) begin n_fail++; $display("FAIL zero_reg: got %0b/%h want 0/0000dead", rw, wd); end
   endtask

   task automatic test_hold_flush();
      logic [31:0] c0;
      idle();
      step();
      step();
      c0 = cnt;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0000_0777, 32'd0, 32'd0, 5'd4);
      hold = 1'b1;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %0b want 0", bus.in_ready); end
      step();
      n_cmp++; if (rw !== 1'b0) begin n_fail++; $display("FAIL hold_bubble: got %0b want 0", rw); end
      flush = 1'b1;
      step();
      n_cmp++; if (rw !== 1'b0) begin n_fail++; $display("FAIL flush_hold_bubble: got %0b want 0", rw); end
      hold = 1'b0;
      step();
      n_cmp++; if (rw !== 1'b0 || cnt !== c0) begin n_fail++; $display("FAIL flush_bubble: got %0b cnt=%0d want 0 cnt=%0d", rw, cnt, c0); end
      flush = 1'b0;
      step();
      n_cmp++; if (rw !== 1'b1 || wd !== 32'h777) begin n_fail++; $display("FAIL after_hold_write: got %0b/%h want 1/00000777", rw, wd); end
      hold = 1'b1;
      step();
      n_cmp++; if (rw !== 1'b0) begin n_fail++; $display("FAIL hold_no_repeat: got %0b want 0", rw); end
      hold = 1'b0;
      idle();
   endtask

   task automatic test_misalign();
      logic [31:0] c0;
      c0 = cnt;
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %0b want 0", err); end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd1, 32'd0, 32'h1234_5678, 32'd0, 5'd6);
      step();
      n_cmp++; if (rw !== 1'b0) begin n_fail++; $display("FAIL misalign_write: got %0b want 0", rw); end
      idle();
      step();
      n_cmp++; if (err !== 1'b1 || cnt !== c0 + 32'd1) begin n_fail++; $display("FAIL misalign_flag: got err=%0b cnt=%0d want 1 cnt=%0d", err, cnt, c0 + 32'd1); end
      for (int i = 0; i < 3; i++) step();
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %0b want 1", err); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
               2'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)));
         hold = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 7) == 0);
         #1;
         n_cmp++; if (bus.in_ready !== !hold) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, bus.in_ready, !hold); end
         step();
         n_cmp++; if (rw !== exp_rw) begin n_fail++; $display("FAIL rnd_regwrite[%0d]: got %0b want %0b", i, rw, exp_rw); end
         if (m_valid) begin
            n_cmp++; if (wr !== exp_wr || wd !== exp_wd) begin n_fail++; $display("FAIL rnd_data[%0d]: got %0d/%h want %0d/%h", i, wr, wd, exp_wr, exp_wd); end
         end
         n_cmp++; if (cnt !== exp_count || err !== exp_err) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d/%0b want %0d/%0b", i, cnt, err, exp_count, exp_err); end
`ifdef WB_FWD_EN
         n_cmp++; if (fv !== rw || fr !== wr || fd !== wd) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %0b/%0d/%h want %0b/%0d/%h", i, fv, fr, fd, exp_rw, exp_wr, exp_wd); end
`endif
      end
      hold = 1'b0;
      flush = 1'b0;
      idle();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'hCAFE_0001, 32'd0, 32'd0, 5'd12);
      step();
      n_cmp++; if (rw !== 1'b1 || cnt !== exp_count) begin n_fail++; $display("FAIL pre_reset: got %0b cnt=%0d want 1 cnt=%0d", rw, cnt, exp_count); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({rw, wr, wd} !== 38'd0 || cnt !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %0b/%0d/%h cnt=%0d err=%0b want all 0", rw, wr, wd, cnt, err); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_valid = 1'b0; m_mis = 1'b0; exp_rw = 1'b0; exp_err = 1'b0; exp_count = 32'd0;
      idle();
      step();
      n_cmp++; if (rw !== 1'b0 || cnt !== 32'd0) begin n_fail++; $display("FAIL reset_dropped: got %0b cnt=%0d want 0 cnt=0", rw, cnt); end
   endtask

   task automatic test_saturation();
      int want;
      for (int n = 1; n <= 23; n++) begin
         bus4.in_valid = (n <= 20);
         step();
         want = (n - 1 > 15) ? 15 : n - 1;
         n_cmp++; if (int'(cnt4) !== want) begin n_fail++; $display("FAIL saturate[%0d]: got %0d want %0d", n, cnt4, want); end
      end
      n_cmp++; if (rw4 !== 1'b0 || err4 !== 1'b0) begin n_fail++; $display("FAIL saturate_tail: got %0b/%0b want 0/0", rw4, err4); end
      bus4.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_link_and_zero();
      test_hold_flush();
      test_misalign();
      test_random();
      test_async_reset();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
